count_bcd_converter: RTL

COUNT_BCD_CONVERTER -- requirements
Module: count_bcd_converter

---
 rtl/bcd_pkg.sv | 26 ++
 rtl/bcd_digit_adj.sv | 18 +
 rtl/count_bcd_converter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the binary-to-BCD converter:
//   - state_t   : converter FSM states (IDLE, SHIFT, DONE)
//   - W_DEF     : default binary input width
//   - ND_DEF    : default number of BCD output digits
//   - cnt_width : width of the shift-iteration counter for a given input width
// -----------------------------------------------------------------------------
package bcd_pkg;

  localparam int W_DEF  = 8;
  localparam int ND_DEF = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // The counter must be able to hold the value w (reached on the final shift)
  // without wrapping, hence w+1 distinct values.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// -----------------------------------------------------------------------------
// bcd_digit_adj
// Double-dabble correction for a single BCD digit: adds 3 when the digit is
// 5 or more, so that the following left shift carries correctly into the next
// decimal digit.
// Ports:
//   d : input  [3:0]  BCD digit before correction (0..9)
//   q : output [3:0]  corrected digit (0..4 unchanged, 5..9 -> 8..12)
// -----------------------------------------------------------------------------
module bcd_digit_adj (
  input  logic [3:0] d,
  output logic [3:0] q
);

  // A legal digit is at most 9, so d + 3 is at most 12 and fits in 4 bits.
  assign q = (d >= 4'd5) ? (d + 4'd3) : d;

endmodule

// File: rtl/count_bcd_converter.sv
// -----------------------------------------------------------------------------
// count_bcd_converter
// Sequential binary-to-BCD converter (shift-and-add-3) for displaying a
// counter value. One input word is converted over W shift cycles; the result
// is held on bcd with a valid/ready handshake until the consumer takes it.
// Ports:
//   clk        : input           clock, rising edge
//   clr_n      : input           synchronous active-low reset
//   din        : input  [W-1:0]  unsigned binary value
//   din_valid  : input           din is valid this cycle
//   din_ready  : output          converter accepts din this cycle
//   bcd        : output [4*ND-1:0] packed BCD result, MS digit in top nibble
//   dout_valid : output          bcd holds a completed conversion
//   dout_ready : input           consumer accepts bcd this cycle
// -----------------------------------------------------------------------------
module count_bcd_converter
  import bcd_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int ND = ND_DEF
) (
  input  logic            clk,
  input  logic            clr_n,
  input  logic [W-1:0]    din,
  input  logic            din_valid,
  output logic            din_ready,
  output logic [4*ND-1:0] bcd,
  output logic            dout_valid,
  input  logic            dout_ready
);

  localparam int CW = cnt_width(W);
  localparam int BW = 4 * ND;

  state_t state_reg, state_next;

  logic [W-1:0]  bin_reg, bin_next;
  logic [BW-1:0] acc_reg, acc_next;
  logic [BW-1:0] acc_adj;
  logic [BW-1:0] bcd_reg;
  logic [CW-1:0] cnt_reg, cnt_next;

  logic accept;
  logic last_shift;

  assign accept     = din_valid && (state_reg == IDLE);
  assign last_shift = (cnt_reg == CW'(W - 1));

  // Per-digit add-3 correction applied to the accumulator before each shift.
  genvar gi;
  generate
    for (gi = 0; gi < ND; gi++) begin : g_adj
      bcd_digit_adj u_adj (
        .d (acc_reg[4*gi +: 4]),
        .q (acc_adj[4*gi +: 4])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept)     state_next = SHIFT;
      SHIFT:   if (last_shift) state_next = DONE;
      DONE:    if (dout_ready) state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // din_ready is gated by clr_n so no handshake appears during reset.
    din_ready  = (state_reg == IDLE) && clr_n;
    dout_valid = (state_reg == DONE);
  end

  assign bcd = bcd_reg;

  // ---------------------------------------------------------------------------
  // Datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    bin_next = bin_reg;
    acc_next = acc_reg;
    cnt_next = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          bin_next = din;
          acc_next = '0;
          cnt_next = '0;
        end
      end
      SHIFT: begin
        // One left shift of {accumulator, binary}; the binary MSB enters the
        // accumulator LSB.
        acc_next = {acc_adj[BW-2:0], bin_reg[W-1]};
        bin_next = {bin_reg[W-2:0], 1'b0};
        cnt_next = cnt_reg + CW'(1);
      end
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      bin_reg <= '0;
      acc_reg <= '0;
      cnt_reg <= '0;
      bcd_reg <= '0;
    end else begin
      bin_reg <= bin_next;
      acc_reg <= acc_next;
      cnt_reg <= cnt_next;
      // The visible result only changes when a conversion completes, so the
      // consumer never sees partial shift values.
      if ((state_reg == SHIFT) && last_shift) begin
        bcd_reg <= acc_next;
      end
    end
  end

endmodule
